// File: rtl/alu_pkg.sv
// Shared types for the ALU issue controller: opcodes, flag positions, FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_NOT = 4'd6,
        OP_NEG = 4'd7,
        OP_CMP = 4'd8
    } alu_op_e;

    localparam int FLAG_EQ = 0;
    localparam int FLAG_LT = 1;
    localparam int FLAG_GT = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB,
        S_RESP
    } issue_state_e;

    function automatic logic is_legal_op(input logic [31:0] op);
        return op <= 32'(OP_CMP);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two combinational read ports, one synchronous write port.
// Entry 0 is hardwired to zero.
module alu_regfile #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8,
    parameter int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IDX_W-1:0]      raddr_a_i,
    input  logic [IDX_W-1:0]      raddr_b_i,
    output logic [DATA_WIDTH-1:0] rdata_a_o,
    output logic [DATA_WIDTH-1:0] rdata_b_o,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i
);

    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller between decode and the ALU: one op in flight, 5-cycle FSM.
// Optional performance counters enabled by defining ALU_ISSUE_PERF_EN.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int OPCODE_WIDTH = 4,
    parameter int NUM_REGS     = 8,
    localparam int IDX_W       = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [OPCODE_WIDTH-1:0] req_opcode,
    input  logic [IDX_W-1:0]        req_rd,
    input  logic [IDX_W-1:0]        req_ra,
    input  logic [IDX_W-1:0]        req_rb,
    input  logic                    req_imm_en,
    input  logic [DATA_WIDTH-1:0]   req_imm,
    output logic [DATA_WIDTH-1:0]   alu_op_a,
    output logic [DATA_WIDTH-1:0]   alu_op_b,
    output logic [OPCODE_WIDTH-1:0] alu_opcode,
    output logic                    alu_active,
    input  logic [DATA_WIDTH-1:0]   alu_result,
    input  logic                    alu_equal,
    input  logic                    alu_less,
    input  logic                    alu_greater,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [2:0]              rsp_flags,
    output logic                    rsp_err,
    output logic [31:0]             perf_issued,
    output logic [31:0]             perf_illegal
);

    localparam logic [OPCODE_WIDTH-1:0] CMP_OP = OPCODE_WIDTH'(OP_CMP);

    issue_state_e state_q, state_d;

    logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
    logic [IDX_W-1:0]        rd_q, rd_d;
    logic [IDX_W-1:0]        ra_q, ra_d;
    logic [IDX_W-1:0]        rb_q, rb_d;
    logic                    imm_en_q, imm_en_d;
    logic [DATA_WIDTH-1:0]   imm_q, imm_d;
    logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [OPCODE_WIDTH-1:0] alu_opc_q, alu_opc_d;
    logic [DATA_WIDTH-1:0]   res_q, res_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [2:0]              rsp_flags_q, rsp_flags_d;
    logic                    rsp_err_q, rsp_err_d;

    logic [DATA_WIDTH-1:0]   rf_a, rf_b;
    logic                    rf_we;
    logic                    op_legal;

    assign op_legal = is_legal_op(32'(opcode_q));
    assign rf_we    = (state_q == S_WB) && (opcode_q < CMP_OP);

    alu_regfile #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W)
    ) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr_a_i(ra_q),
        .raddr_b_i(rb_q),
        .rdata_a_o(rf_a),
        .rdata_b_o(rf_b),
        .we_i     (rf_we),
        .waddr_i  (rd_q),
        .wdata_i  (res_q)
    );

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        rd_d        = rd_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        imm_en_d    = imm_en_q;
        imm_d       = imm_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_opc_d   = alu_opc_q;
        res_d       = res_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    opcode_d = req_opcode;
                    rd_d     = req_rd;
                    ra_d     = req_ra;
                    rb_d     = req_rb;
                    imm_en_d = req_imm_en;
                    imm_d    = req_imm;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                // ALU-facing regs only change for legal ops so they hold last EXEC values
                if (op_legal) begin
                    alu_a_d   = rf_a;
                    alu_b_d   = imm_en_q ? imm_q : rf_b;
                    alu_opc_d = opcode_q;
                    state_d   = S_EXEC;
                end else begin
                    rsp_data_d  = '0;
                    rsp_flags_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_EXEC: begin
                res_d   = alu_result;
                state_d = S_WB;
            end
            S_WB: begin
                rsp_data_d           = (opcode_q == CMP_OP) ? '0 : res_q;
                rsp_flags_d[FLAG_GT] = alu_greater;
                rsp_flags_d[FLAG_LT] = alu_less;
                rsp_flags_d[FLAG_EQ] = alu_equal;
                rsp_err_d            = 1'b0;
                state_d              = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            opcode_q    <= '0;
            rd_q        <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            imm_en_q    <= 1'b0;
            imm_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_opc_q   <= '0;
            res_q       <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            rd_q        <= rd_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            imm_en_q    <= imm_en_d;
            imm_q       <= imm_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_opc_q   <= alu_opc_d;
            res_q       <= res_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign alu_active = (state_q == S_EXEC);
    assign rsp_valid  = (state_q == S_RESP);
    assign alu_op_a   = alu_a_q;
    assign alu_op_b   = alu_b_q;
    assign alu_opcode = alu_opc_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] issued_q, issued_d;
    logic [31:0] illegal_q, illegal_d;

    always_comb begin
        issued_d  = issued_q;
        illegal_d = illegal_q;
        if (state_q == S_EXEC && issued_q != 32'hFFFF_FFFF) begin
            issued_d = issued_q + 32'd1;
        end
        if (state_q == S_READ && !op_legal && illegal_q != 32'hFFFF_FFFF) begin
            illegal_d = illegal_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q  <= '0;
            illegal_q <= '0;
        end else begin
            issued_q  <= issued_d;
            illegal_q <= illegal_d;
        end
    end

    assign perf_issued  = issued_q;
    assign perf_illegal = illegal_q;
`else
    assign perf_issued  = 32'd0;
    assign perf_illegal = 32'd0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed table, reset corner, random ops.
// Checks perf counters against ALU_ISSUE_PERF_EN when that macro is defined.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_opcode = '0;
    logic [2:0]  req_rd = '0;
    logic [2:0]  req_ra = '0;
    logic [2:0]  req_rb = '0;
    logic        req_imm_en = 1'b0;
    logic [15:0] req_imm = '0;
    logic [15:0] alu_op_a, alu_op_b;
    logic [3:0]  alu_opcode;
    logic        alu_active;
    logic [15:0] alu_result;
    logic        alu_equal, alu_less, alu_greater;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_flags;
    logic        rsp_err;
    logic [31:0] perf_issued, perf_illegal;

    int tests = 0;
    int failed = 0;

    logic [15:0] rf_m [8];
    logic [2:0]  flags_m;
    int          iss_m, ill_m;

    always #5 clk = ~clk;

    alu_issue_ctrl #(
        .DATA_WIDTH  (16),
        .OPCODE_WIDTH(4),
        .NUM_REGS    (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opcode  (req_opcode),
        .req_rd      (req_rd),
        .req_ra      (req_ra),
        .req_rb      (req_rb),
        .req_imm_en  (req_imm_en),
        .req_imm     (req_imm),
        .alu_op_a    (alu_op_a),
        .alu_op_b    (alu_op_b),
        .alu_opcode  (alu_opcode),
        .alu_active  (alu_active),
        .alu_result  (alu_result),
        .alu_equal   (alu_equal),
        .alu_less    (alu_less),
        .alu_greater (alu_greater),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_flags   (rsp_flags),
        .rsp_err     (rsp_err),
        .perf_issued (perf_issued),
        .perf_illegal(perf_illegal)
    );

    // ALU stand-in: combinational result, flags registered on active CMP
    always_comb begin
        case (alu_opcode)
            4'd0:    alu_result = alu_op_a + alu_op_b;
            4'd1:    alu_result = alu_op_a - alu_op_b;
            4'd2:    alu_result = alu_op_a * alu_op_b;
            4'd3:    alu_result = alu_op_a & alu_op_b;
            4'd4:    alu_result = alu_op_a | alu_op_b;
            4'd5:    alu_result = alu_op_a ^ alu_op_b;
            4'd6:    alu_result = ~alu_op_a;
            4'd7:    alu_result = 16'd0 - alu_op_a;
            default: alu_result = 16'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_equal   <= 1'b0;
            alu_less    <= 1'b0;
            alu_greater <= 1'b0;
        end else if (alu_active && alu_opcode == 4'd8) begin
            alu_equal   <= (alu_op_a == alu_op_b);
            alu_less    <= (alu_op_a < alu_op_b);
            alu_greater <= (alu_op_a > alu_op_b);
        end
    end

    function automatic logic [15:0] ref_alu(input logic [3:0] op,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
        int unsigned ua, ub;
        ua = a;
        ub = b;
        case (op)
            4'd0: return 16'((ua + ub) % 65536);
            4'd1: return 16'((ua + 65536 - ub) % 65536);
            4'd2: return 16'((ua * ub) % 65536);
            4'd3: return a & b;
            4'd4: return a | b;
            4'd5: return a ^ b;
            4'd6: return 16'(65535 - ua);
            4'd7: return 16'((65536 - ua) % 65536);
            default: return 16'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) rf_m[i] = 16'd0;
        flags_m = 3'b000;
        iss_m = 0;
        ill_m = 0;
    endtask

    // Runs one op end to end; returns observed response and the model's prediction.
    task automatic do_op(input logic [3:0] op, input logic [2:0] rd,
                         input logic [2:0] ra, input logic [2:0] rb,
                         input logic ie, input logic [15:0] imm,
                         input int stall,
                         output logic [15:0] d, output logic [2:0] f,
                         output logic e,
                         output logic [15:0] md, output logic [2:0] mf,
                         output logic me);
        logic legal;
        logic [15:0] a, b, r;
        int n, lat, act, busy_bad;
        legal = (op <= 4'd8);
        a = rf_m[ra];
        b = ie ? imm : rf_m[rb];
        r = ref_alu(op, a, b);
        me = !legal;
        md = (legal && op != 4'd8) ? r : 16'd0;
        if (op == 4'd8) mf = {a > b, a < b, a == b};
        else if (legal) mf = flags_m;
        else mf = 3'b000;

        @(negedge clk);
        req_valid = 1'b1;
        req_opcode = op;
        req_rd = rd;
        req_ra = ra;
        req_rb = rb;
        req_imm_en = ie;
        req_imm = imm;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_timeout", 64'(n < 20), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_imm = $urandom;
        lat = 1;
        act = 0;
        busy_bad = 0;
        while (!rsp_valid && lat < 12) begin
            if (alu_active) act++;
            if (req_ready) busy_bad++;
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), legal ? 64'd4 : 64'd2);
        chk("alu_active_pulses", 64'(act), legal ? 64'd1 : 64'd0);
        chk("busy_req_ready_low", 64'(busy_bad), 64'd0);
        d = rsp_data;
        f = rsp_flags;
        e = rsp_err;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_stable",
                {rsp_valid, req_ready, alu_active, rsp_data, rsp_flags, rsp_err},
                {1'b1, 1'b0, 1'b0, d, f, e});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("ready_after_rsp", {req_ready, rsp_valid}, 2'b10);

        if (legal && op < 4'd8 && rd != 3'd0) rf_m[rd] = r;
        if (op == 4'd8) flags_m = mf;
        if (legal) iss_m++;
        else ill_m++;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rd, ra, rb;
        logic        ie;
        logic [15:0] imm;
        int          stall;
        logic [15:0] ed;
        logic [2:0]  ef;
        logic        ee;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [15:0] d, md;
        logic [2:0]  f, mf;
        logic        e, me;
        int          n;

        tbl[0]  = '{4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005, 0, 16'h0005, 3'b000, 1'b0};
        tbl[1]  = '{4'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0003, 1, 16'h0003, 3'b000, 1'b0};
        tbl[2]  = '{4'd1, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 0, 16'h0002, 3'b000, 1'b0};
        tbl[3]  = '{4'd8, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 5, 16'h0000, 3'b100, 1'b0};
        tbl[4]  = '{4'd0, 3'd4, 3'd3, 3'd0, 1'b1, 16'h0000, 0, 16'h0002, 3'b100, 1'b0};
        tbl[5]  = '{4'd0, 3'd4, 3'd0, 3'd0, 1'b1, 16'h0100, 0, 16'h0100, 3'b100, 1'b0};
        tbl[6]  = '{4'd2, 3'd5, 3'd4, 3'd0, 1'b1, 16'h0100, 0, 16'h0000, 3'b100, 1'b0};
        tbl[7]  = '{4'd0, 3'd6, 3'd0, 3'd0, 1'b1, 16'h0001, 0, 16'h0001, 3'b100, 1'b0};
        tbl[8]  = '{4'd7, 3'd7, 3'd6, 3'd0, 1'b1, 16'h0000, 2, 16'hFFFF, 3'b100, 1'b0};
        tbl[9]  = '{4'hA, 3'd1, 3'd1, 3'd2, 1'b0, 16'h0000, 1, 16'h0000, 3'b000, 1'b1};
        tbl[10] = '{4'd0, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0000, 0, 16'h0005, 3'b100, 1'b0};
        tbl[11] = '{4'd0, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0007, 0, 16'h0007, 3'b100, 1'b0};
        tbl[12] = '{4'd8, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0000, 0, 16'h0000, 3'b001, 1'b0};
        tbl[13] = '{4'd5, 3'd3, 3'd7, 3'd0, 1'b1, 16'h0F0F, 0, 16'hF0F0, 3'b001, 1'b0};

        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {req_ready, rsp_valid, alu_active, rsp_data, rsp_flags, rsp_err},
            {1'b1, 1'b0, 1'b0, 16'h0, 3'b000, 1'b0});
        chk("reset_alu_drive", {alu_op_a, alu_op_b, alu_opcode}, 36'h0);
        chk("reset_perf", {perf_issued, perf_illegal}, 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            do_op(tbl[i].op, tbl[i].rd, tbl[i].ra, tbl[i].rb, tbl[i].ie,
                  tbl[i].imm, tbl[i].stall, d, f, e, md, mf, me);
            chk($sformatf("vec%0d_rsp", i), {d, f, e},
                {tbl[i].ed, tbl[i].ef, tbl[i].ee});
        end

        // Reset during EXEC aborts the op and clears the register file
        do_op(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0055, 0, d, f, e, md, mf, me);
        chk("pre_reset_r1", 64'(d), 64'h55);
        @(negedge clk);
        req_valid = 1'b1;
        req_opcode = 4'd0;
        req_rd = 3'd1;
        req_ra = 3'd0;
        req_imm_en = 1'b1;
        req_imm = 16'h0009;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!alu_active && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("reach_exec", 64'(n < 10), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midop_reset_outputs",
            {req_ready, rsp_valid, alu_active, rsp_data, rsp_err},
            {1'b1, 1'b0, 1'b0, 16'h0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        chk("no_rsp_after_abort", 64'(n), 64'd0);
        do_op(4'd0, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0000, 0, d, f, e, md, mf, me);
        chk("r1_cleared", {d, f, e}, {16'h0000, 3'b000, 1'b0});

        // Random ops against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(9, 15))
                                             : 4'($urandom_range(0, 8));
            do_op(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  16'($urandom), $urandom_range(0, 3), d, f, e, md, mf, me);
            chk($sformatf("rand%0d_op%0h", i, op), {d, f, e}, {md, mf, me});
        end

`ifdef ALU_ISSUE_PERF_EN
        chk("perf_issued", 64'(perf_issued), 64'(iss_m));
        chk("perf_illegal", 64'(perf_illegal), 64'(ill_m));
`else
        chk("perf_issued_tied", 64'(perf_issued), 64'd0);
        chk("perf_illegal_tied", 64'(perf_illegal), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
